// File: rtl/pacman_keycode_ctrl.sv
// Keycode-to-direction sequencer for the Pacman movement engine: decode, press edges,
// frame-paced auto-repeat and a direction FIFO. Optional: KEYCODE_CTRL_OPPOSITE_FLUSH_EN.
module pacman_keycode_ctrl #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned DELAY_FRAMES  = 12,
    parameter int unsigned REPEAT_FRAMES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               keycode,
    input  logic                     frame_tick,
    input  logic                     dir_ready,
    output logic                     dir_valid,
    output logic [1:0]               dir,
    output logic                     pause_pulse,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int unsigned PtrW      = $clog2(DEPTH);
    localparam int unsigned LvlW      = PtrW + 1;
    localparam int unsigned MaxFrames = (DELAY_FRAMES > REPEAT_FRAMES) ? DELAY_FRAMES
                                                                        : REPEAT_FRAMES;
    localparam int unsigned CntW      = $clog2(MaxFrames + 1);
    localparam logic [CntW-1:0] DelayLast  = CntW'(DELAY_FRAMES - 1);
    localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    logic [7:0]      kc_q, kc_prev_q;
    logic            kc_is_dir, kc_changed, press;
    logic [1:0]      kc_dir;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push;

    logic [1:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q;
    logic [1:0]      last_q;
    logic            overflow_q;
    logic            fifo_empty, fifo_full, pop, collapse, flush, wr, drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kc_q      <= 8'h00;
            kc_prev_q <= 8'h00;
        end else begin
            kc_q      <= keycode;
            kc_prev_q <= kc_q;
        end
    end

    always_comb begin
        kc_is_dir = 1'b1;
        kc_dir    = 2'b00;
        case (kc_q)
            8'h1A, 8'h52: kc_dir = 2'b00;
            8'h04, 8'h50: kc_dir = 2'b01;
            8'h16, 8'h51: kc_dir = 2'b10;
            8'h07, 8'h4F: kc_dir = 2'b11;
            default:      kc_is_dir = 1'b0;
        endcase
    end

    assign kc_changed  = (kc_q != kc_prev_q);
    assign press       = kc_changed && kc_is_dir;
    assign pause_pulse = kc_changed && (kc_q == 8'h13);

    // Repeat FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Repeat FSM: next state; any keycode change overrides the timers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kc_changed) begin
            state_d = kc_is_dir ? StDelay : StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StDelay: begin
                    if (frame_tick) begin
                        if (cnt_q == DelayLast) begin
                            state_d = StRepeat;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                StRepeat: begin
                    if (frame_tick) begin
                        cnt_d = (cnt_q == RepeatLast) ? '0 : cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Repeat FSM: push requests
    always_comb begin
        push = 1'b0;
        if (kc_changed) begin
            push = kc_is_dir;
        end else begin
            case (state_q)
                StDelay:  push = frame_tick && (cnt_q == DelayLast);
                StRepeat: push = frame_tick && (cnt_q == RepeatLast);
                default:  push = 1'b0;
            endcase
        end
    end

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LvlW'(DEPTH));
    assign pop        = !fifo_empty && dir_ready;
    assign collapse   = !fifo_empty && (kc_dir == last_q);
`ifdef KEYCODE_CTRL_OPPOSITE_FLUSH_EN
    // Opposite of the newest entry: discard pending turns, keep only the reversal
    assign flush      = press && !fifo_empty && (kc_dir == (last_q ^ 2'b10));
`else
    assign flush      = 1'b0;
`endif
    assign wr         = push && !collapse && !flush && (!fifo_full || pop);
    assign drop       = push && !collapse && !flush && fifo_full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else if (flush) begin
            mem_q[0] <= kc_dir;
            rd_ptr_q <= '0;
            wr_ptr_q <= PtrW'(1);
            level_q  <= LvlW'(1);
            last_q   <= kc_dir;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= kc_dir;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
                last_q          <= kc_dir;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({wr, pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign dir_valid  = !fifo_empty;
    assign dir        = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule
